// File: rtl/fir_pkg.sv
// Shared types for the time-multiplexed FIR engine: sample, coefficient and
// product types, scheduler states and the accumulator width helper.
package fir_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic        [7:0]  coef_t;
    typedef logic signed [23:0] prod_t;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    // 24-bit products summed over NTAPS taps need clog2(NTAPS) guard bits.
    function automatic int acc_w(input int ntaps);
        return 24 + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_mul_16s_8u.sv
// Combinational signed 16-bit x unsigned 8-bit multiplier. The coefficient is
// zero-extended to 9 bits so the product is a plain signed multiply; the full
// result always fits in 24 signed bits (|-32768 * 255| < 2^23).
module fir_mul_16s_8u
    import fir_pkg::*;
(
    input  sample_t a_i,
    input  coef_t   b_i,
    output prod_t   p_o
);

    logic signed [8:0] b_ext;

    assign b_ext = $signed({1'b0, b_i});
    assign p_o   = prod_t'(a_i) * prod_t'(b_ext);

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one shared multiplier walks all NTAPS taps per input
// sample (one product per cycle, registered, then accumulated), followed by a
// single drain cycle and an output handshake.
// Optional feature macro: FIR_SAT_EN (saturate output to 16 bits and keep a
// sticky clip flag); without it the output wraps to the low 16 bits.
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int NTAPS = 16,
    parameter int SHIFT = 8
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [15:0]              x_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic [15:0]              y_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [7:0]               coef_data,
    output logic                     coef_err,
    output logic                     busy
);

    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = acc_w(NTAPS);

    state_t                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q;
    logic [AW:0]             k_q;
    sample_t                 delay_q [NTAPS];
    coef_t                   coef_q  [NTAPS];
    prod_t                   prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [15:0]             y_q;
    logic                    err_q;

    logic                    accept;
    logic                    drain;
    logic [AW-1:0]           rd_idx;
    sample_t                 mul_a;
    coef_t                   mul_b;
    prod_t                   mul_p;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [15:0]             y_next;

    // Tap k reads the sample written k samples ago; pointer arithmetic wraps.
    assign rd_idx   = wr_ptr_q - k_q[AW-1:0];
    assign mul_a    = delay_q[rd_idx];
    assign mul_b    = coef_q[k_q[AW-1:0]];
    assign prod_ext = {{(ACC_W-24){prod_q[23]}}, prod_q};
    assign acc_sum  = acc_q + prod_ext;

    fir_mul_16s_8u u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic signed [ACC_W-1:0] acc_shr;
    logic                    clip_hi;
    logic                    clip_lo;
    logic                    sat_flag_q;
    logic [7:0]              status;

    assign acc_shr = acc_sum >>> SHIFT;
    assign clip_hi = acc_shr > SAT_MAX;
    assign clip_lo = acc_shr < SAT_MIN;
    assign y_next  = clip_hi ? 16'h7fff : (clip_lo ? 16'h8000 : acc_shr[15:0]);
    assign status  = {sat_flag_q, 7'd0};

    // Sticky clip flag, only cleared by reset; visible through status[7].
    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            sat_flag_q <= 1'b0;
        else if (drain && (clip_hi || clip_lo))
            sat_flag_q <= 1'b1;
    end
`else
    assign y_next = 16'(acc_sum >>> SHIFT);
`endif

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state plus the accept/drain strobes that steer the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drain   = 1'b0;
        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (k_q == (AW+1)'(NTAPS)) begin
                    drain   = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (y_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: delay line, coefficients, product register, accumulator, output.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            k_q      <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                delay_q[wr_ptr_q] <= x_data;
                acc_q             <= '0;
                k_q               <= '0;
            end
            if (state_q == MAC) begin
                // Issue cycles k=0..NTAPS-1 fill the product register; each
                // following cycle (including the drain) folds it into acc.
                if (k_q != (AW+1)'(NTAPS)) begin
                    prod_q <= mul_p;
                    k_q    <= k_q + (AW+1)'(1);
                end
                if (k_q != '0)
                    acc_q <= acc_sum;
                if (drain) begin
                    y_q      <= y_next;
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
            end
            // Writes while idle land before the next sample's first tap read.
            if (coef_we && !busy)
                coef_q[coef_addr] <= coef_data;
            err_q <= coef_we && busy;
        end
    end

    assign x_ready  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign y_valid  = (state_q == OUT);
    assign y_data   = y_q;
    assign coef_err = err_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler (NTAPS=16, SHIFT=0) with a sample-level
// reference model checked every cycle plus hand-computed literal expectations.
module tb_fir_mac_scheduler;

    localparam int NTAPS = 16;
    localparam int SHIFT = 0;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [15:0] x_data = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [15:0] y_data;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic        coef_err;
    logic        busy;

    always #5 ap_clk = ~ap_clk;

    fir_mac_scheduler #(.NTAPS(NTAPS), .SHIFT(SHIFT)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .x_data    (x_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_err  (coef_err),
        .busy      (busy)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_to(input string nm);
        n_tot++;
        $display("FAIL %s: timeout got none expected event (t=%0t)", nm, $time);
    endtask

    // Reference model: coefficient table, accepted-sample history, and the
    // cycle count since the current sample was accepted.
    int  coef_m [NTAPS];
    int  hist[$];
    bit  m_act;
    int  m_t;
    int  m_y;
    bit  m_err;
    int  cyc;
    bit  chk_en;
    int  got_q[$];
    int  acc_cyc[$];
    int  err_cnt;
    int  yv_cnt;

    function automatic int model_y();
        longint s = 0;
        int n = hist.size() - 1;
        for (int k = 0; k < NTAPS; k++)
            if (n - k >= 0) s += longint'(coef_m[k]) * longint'(hist[n - k]);
        s = s >>> SHIFT;
`ifdef FIR_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
`else
        return int'(shortint'(s));
`endif
    endfunction

    // Compare DUT outputs against the model mid-cycle, then advance the model
    // with the inputs the DUT will sample on the coming rising edge.
    always @(negedge ap_clk) begin
        cyc++;
        if (chk_en) begin
            chk("x_ready", longint'(x_ready), longint'(!m_act));
            chk("busy", longint'(busy), longint'(m_act));
            chk("y_valid", longint'(y_valid), longint'(m_act && m_t >= NTAPS + 2));
            chk("coef_err", longint'(coef_err), longint'(m_err));
            if (m_act && m_t >= NTAPS + 2)
                chk("y_data", longint'($signed(y_data)), longint'(m_y));
            if (y_valid && y_ready) got_q.push_back(int'($signed(y_data)));
            if (x_valid && x_ready) acc_cyc.push_back(cyc);
            if (coef_err) err_cnt++;
            if (y_valid) yv_cnt++;
        end
        if (ap_rst) begin
            for (int i = 0; i < NTAPS; i++) coef_m[i] = 0;
            hist.delete();
            m_act = 0;
            m_t   = 0;
            m_err = 0;
        end else begin
            m_err = coef_we && m_act;
            if (coef_we && !m_act) coef_m[coef_addr] = int'(coef_data);
            if (!m_act) begin
                if (x_valid) begin
                    hist.push_back(int'($signed(x_data)));
                    m_y   = model_y();
                    m_act = 1;
                    m_t   = 1;
                end
            end else if (m_t >= NTAPS + 2 && y_ready) begin
                m_act = 0;
            end else begin
                m_t++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #2;
        end
    endtask

    task automatic wr_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 8'(d);
        step(1);
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] s);
        int b = 0;
        x_data  = s;
        x_valid = 1'b1;
        forever begin
            @(negedge ap_clk);
            if (x_ready) begin
                @(posedge ap_clk);
                #2;
                x_valid = 1'b0;
                return;
            end
            b++;
            if (b > 200) begin
                fail_to("send");
                x_valid = 1'b0;
                step(1);
                return;
            end
        end
    endtask

    task automatic wait_outs(input int n);
        int b = 0;
        while (got_q.size() < n) begin
            step(1);
            b++;
            if (b > 2000) begin
                fail_to("wait_outs");
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int b;
        int idx;

        step(3);
        ap_rst = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        @(negedge ap_clk);
        chk("rst_x_ready", longint'(x_ready), 1);
        chk("rst_y_valid", longint'(y_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_coef_err", longint'(coef_err), 0);
        chk("rst_y_data", longint'(y_data), 0);
        @(posedge ap_clk);
        #2;

        // Impulse through coef[k]=k+1: outputs 1..16, then 0.
        for (int k = 0; k < NTAPS; k++) wr_coef(k, k + 1);
        got_q.delete();
        send(16'd1);
        for (int i = 0; i < NTAPS; i++) send(16'd0);
        wait_outs(NTAPS + 1);
        if (got_q.size() >= NTAPS + 1) begin
            for (int i = 0; i < NTAPS; i++) chk($sformatf("impulse_y%0d", i), got_q[i], i + 1);
            chk("impulse_y16", got_q[NTAPS], 0);
        end

        // Extreme: all coef 255, sixteen -32768 samples.
        for (int k = 0; k < NTAPS; k++) wr_coef(k, 255);
        got_q.delete();
        for (int i = 0; i < NTAPS; i++) send(16'h8000);
        wait_outs(NTAPS);
        if (got_q.size() >= NTAPS) begin
`ifdef FIR_SAT_EN
            chk("extreme_y15", got_q[NTAPS-1], -32768);
`else
            chk("extreme_y15", got_q[NTAPS-1], 0);
`endif
        end

        // Backpressure: hold y_ready low while y_valid is up.
        y_ready = 1'b0;
        send(16'd100);
        b = 0;
        @(negedge ap_clk);
        while (!y_valid && b < 100) begin
            @(negedge ap_clk);
            b++;
        end
        if (!y_valid) fail_to("bp_y_valid");
        v = int'(y_data);
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            chk("bp_y_stable", longint'(y_data), longint'(v));
            chk("bp_x_ready", longint'(x_ready), 0);
        end
        @(posedge ap_clk);
        #2;
        y_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_y_held", longint'(y_valid), 1);
        @(negedge ap_clk);
        chk("bp_idle_x_ready", longint'(x_ready), 1);
        chk("bp_idle_y_valid", longint'(y_valid), 0);
        @(posedge ap_clk);
        #2;

        // Throughput: continuous valid/ready, one accept per NTAPS+3 cycles.
        idx = acc_cyc.size();
        x_data  = 16'd5;
        x_valid = 1'b1;
        step((NTAPS + 3) * 4 + 5);
        x_valid = 1'b0;
        step(NTAPS + 6);
        chk("tput_accepts", longint'(acc_cyc.size() - idx >= 4), 1);
        for (int i = idx + 1; i < acc_cyc.size(); i++)
            chk("tput_gap", acc_cyc[i] - acc_cyc[i-1], NTAPS + 3);

        // Coefficient write while busy is dropped with one error pulse.
        err_cnt = 0;
        send(16'd7);
        step(2);
        wr_coef(0, 9);
        step(NTAPS + 6);
        chk("busy_wr_err_pulses", err_cnt, 1);

        // Reset at MAC cycle 5 aborts the sample and clears coefficients.
        yv_cnt = 0;
        send(16'd3);
        step(4);
        ap_rst = 1'b1;
        step(1);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_mid_x_ready", longint'(x_ready), 1);
        chk("rst_mid_no_y_valid", yv_cnt, 0);
        @(posedge ap_clk);
        #2;
        got_q.delete();
        send(16'd1);
        wait_outs(1);
        if (got_q.size() >= 1) chk("rst_mid_impulse_zero", got_q[0], 0);

        step(3);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
